// File: rtl/decode.sv
// decode: ID stage of the 5-stage MIPS pipeline.
//   Decodes the instruction from fetch, resolves j one stage early, holds the
//   32x32 register file, detects load-use hazards and drives the ID/EX
//   pipeline register feeding execute.
// Ports:
//   clk, reset_n            pipeline clock, asynchronous active-low reset
//   flush                   next ID/EX contents become a bubble
//   Instr_ID                instruction word from fetch
//   MemRead_EX, WriteReg_EX load-in-EX info for hazard detection
//   RegWrite_WB, WriteReg_WB, Result_WB   register file write port
//   Jump_IDM1, JumpTgt_IDM1 combinational jump resolution back to fetch
//   LoadStall_ID            combinational load-use stall request
//   *_EX outputs            registered ID/EX pipeline contents
// Optional feature: define REGFILE_BYPASS_EN to make a same-cycle WB write
//   visible on the register read ports (write-through).
module decode #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic [31:0]   Instr_ID,
  input  logic          MemRead_EX,
  input  logic [4:0]    WriteReg_EX,
  input  logic          RegWrite_WB,
  input  logic [4:0]    WriteReg_WB,
  input  logic [DW-1:0] Result_WB,
  output logic          Jump_IDM1,
  output logic [25:0]   JumpTgt_IDM1,
  output logic          LoadStall_ID,
  output logic [DW-1:0] RdData1_EX,
  output logic [DW-1:0] RdData2_EX,
  output logic [DW-1:0] SignImm_EX,
  output logic [4:0]    Rs_EX,
  output logic [4:0]    Rt_EX,
  output logic [4:0]    Rd_EX,
  output logic          RegWrite_EX,
  output logic          MemToReg_EX,
  output logic          MemWrite_EX,
  output logic          MemReadOut_EX,
  output logic          AluSrc_EX,
  output logic          RegDst_EX,
  output logic          Branch_EX,
  output logic [2:0]    AluCtl_EX
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  assign opcode = Instr_ID[31:26];
  assign rs     = Instr_ID[25:21];
  assign rt     = Instr_ID[20:16];
  assign rd     = Instr_ID[15:11];
  assign funct  = Instr_ID[5:0];

  // Register file
  logic [DW-1:0] regs_q [NREG];
  logic          wb_en;
  logic [DW-1:0] rd1_d, rd2_d;

  assign wb_en = RegWrite_WB && (WriteReg_WB != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[WriteReg_WB] <= Result_WB;
    end
  end

  always_comb begin
    rd1_d = (rs == 5'd0) ? '0 : regs_q[rs];
    rd2_d = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef REGFILE_BYPASS_EN
    // wb_en already excludes r0, so r0 still reads zero here
    if (wb_en && (WriteReg_WB == rs)) rd1_d = Result_WB;
    if (wb_en && (WriteReg_WB == rt)) rd2_d = Result_WB;
`else
`endif
  end

  // Control decode
  logic       reg_write_d, mem_to_reg_d, mem_write_d, mem_read_d;
  logic       alu_src_d, reg_dst_d, branch_d, is_j, uses_rt;
  logic [2:0] alu_ctl_d;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    alu_src_d    = 1'b0;
    reg_dst_d    = 1'b0;
    branch_d     = 1'b0;
    alu_ctl_d    = 3'b000;
    is_j         = 1'b0;
    uses_rt      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
        case (funct)
          6'b100000: alu_ctl_d = ALU_ADD;
          6'b100010: alu_ctl_d = ALU_SUB;
          6'b100100: alu_ctl_d = ALU_AND;
          6'b100101: alu_ctl_d = ALU_OR;
          6'b101010: alu_ctl_d = ALU_SLT;
          default: begin
            reg_write_d = 1'b0;
            reg_dst_d   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_src_d    = 1'b1;
        alu_ctl_d    = ALU_ADD;
      end
      OP_SW: begin
        uses_rt     = 1'b1;
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctl_d   = ALU_ADD;
      end
      OP_BEQ: begin
        uses_rt   = 1'b1;
        branch_d  = 1'b1;
        alu_ctl_d = ALU_SUB;
      end
      OP_ADDI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctl_d   = ALU_ADD;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // Load-use hazard; a stalled j must not redirect fetch
  assign LoadStall_ID = MemRead_EX && (WriteReg_EX != 5'd0) &&
                        ((WriteReg_EX == rs) || (uses_rt && (WriteReg_EX == rt)));
  assign Jump_IDM1    = is_j && !LoadStall_ID;
  assign JumpTgt_IDM1 = Instr_ID[25:0];

  // ID/EX pipeline register
  logic bubble;
  assign bubble = flush || LoadStall_ID;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RdData1_EX    <= '0;
      RdData2_EX    <= '0;
      SignImm_EX    <= '0;
      Rs_EX         <= '0;
      Rt_EX         <= '0;
      Rd_EX         <= '0;
      RegWrite_EX   <= 1'b0;
      MemToReg_EX   <= 1'b0;
      MemWrite_EX   <= 1'b0;
      MemReadOut_EX <= 1'b0;
      AluSrc_EX     <= 1'b0;
      RegDst_EX     <= 1'b0;
      Branch_EX     <= 1'b0;
      AluCtl_EX     <= 3'b000;
    end else begin
      RdData1_EX    <= rd1_d;
      RdData2_EX    <= rd2_d;
      SignImm_EX    <= {{(DW-16){Instr_ID[15]}}, Instr_ID[15:0]};
      Rs_EX         <= rs;
      Rt_EX         <= rt;
      Rd_EX         <= rd;
      RegWrite_EX   <= reg_write_d  && !bubble;
      MemToReg_EX   <= mem_to_reg_d && !bubble;
      MemWrite_EX   <= mem_write_d  && !bubble;
      MemReadOut_EX <= mem_read_d   && !bubble;
      AluSrc_EX     <= alu_src_d    && !bubble;
      RegDst_EX     <= reg_dst_d    && !bubble;
      Branch_EX     <= branch_d     && !bubble;
      AluCtl_EX     <= bubble ? 3'b000 : alu_ctl_d;
    end
  end

endmodule

// File: tb/tb_decode.sv
module tb_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [31:0] Instr_ID;
  logic        MemRead_EX;
  logic [4:0]  WriteReg_EX;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] Result_WB;
  logic        Jump_IDM1;
  logic [25:0] JumpTgt_IDM1;
  logic        LoadStall_ID;
  logic [31:0] RdData1_EX, RdData2_EX, SignImm_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic        RegWrite_EX, MemToReg_EX, MemWrite_EX, MemReadOut_EX;
  logic        AluSrc_EX, RegDst_EX, Branch_EX;
  logic [2:0]  AluCtl_EX;

  always #5 clk = ~clk;

  decode #(.NREG(32), .DW(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .Instr_ID(Instr_ID),
    .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX),
    .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .Result_WB(Result_WB),
    .Jump_IDM1(Jump_IDM1), .JumpTgt_IDM1(JumpTgt_IDM1), .LoadStall_ID(LoadStall_ID),
    .RdData1_EX(RdData1_EX), .RdData2_EX(RdData2_EX), .SignImm_EX(SignImm_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX),
    .MemReadOut_EX(MemReadOut_EX), .AluSrc_EX(AluSrc_EX), .RegDst_EX(RegDst_EX),
    .Branch_EX(Branch_EX), .AluCtl_EX(AluCtl_EX)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [9:0]  ctl;
    logic [31:0] rd1, rd2, simm;
    logic [4:0]  rs, rt, rd;
    bit          bubble;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];

  // {RegWrite,MemToReg,MemWrite,MemRead,AluSrc,RegDst,Branch,AluCtl[2:0]}
  function automatic logic [9:0] model_ctl(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: return 10'b1000010_010;
          6'b100010: return 10'b1000010_110;
          6'b100100: return 10'b1000010_000;
          6'b100101: return 10'b1000010_001;
          6'b101010: return 10'b1000010_111;
          default:   return 10'b0;
        endcase
      end
      6'b100011: return 10'b1101100_010;
      6'b101011: return 10'b0010100_010;
      6'b000100: return 10'b0000001_110;
      6'b001000: return 10'b1000100_010;
      default:   return 10'b0;
    endcase
  endfunction

  function automatic logic [9:0] obs_ctl();
    return {RegWrite_EX, MemToReg_EX, MemWrite_EX, MemReadOut_EX, AluSrc_EX,
            RegDst_EX, Branch_EX, AluCtl_EX};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite_WB && WriteReg_WB != 5'd0 && WriteReg_WB == idx) return Result_WB;
`endif
    return mregs[idx];
  endfunction

  task automatic step(input string tag, input logic [31:0] ins,
                      input logic mr, input logic [4:0] wex,
                      input logic rw, input logic [4:0] wwb, input logic [31:0] res,
                      input logic fl);
    exp_t e;
    logic stall, urt, isj;
    @(negedge clk);
    Instr_ID = ins; MemRead_EX = mr; WriteReg_EX = wex;
    RegWrite_WB = rw; WriteReg_WB = wwb; Result_WB = res; flush = fl;
    #1;
    urt   = (ins[31:26] == 6'b000000) || (ins[31:26] == 6'b000100) || (ins[31:26] == 6'b101011);
    stall = mr && (wex != 5'd0) && ((wex == ins[25:21]) || (urt && wex == ins[20:16]));
    isj   = (ins[31:26] == 6'b000010);
    check_eq({tag, ".stall"}, {31'b0, LoadStall_ID}, {31'b0, stall});
    check_eq({tag, ".jump"},  {31'b0, Jump_IDM1}, {31'b0, isj && !stall});
    check_eq({tag, ".tgt"},   {6'b0, JumpTgt_IDM1}, {6'b0, ins[25:0]});
    e.tag    = tag;
    e.bubble = fl || stall;
    e.ctl    = e.bubble ? 10'b0 : model_ctl(ins);
    e.rd1    = model_read(ins[25:21]);
    e.rd2    = model_read(ins[20:16]);
    e.simm   = {{16{ins[15]}}, ins[15:0]};
    e.rs     = ins[25:21];
    e.rt     = ins[20:16];
    e.rd     = ins[15:11];
    sb.push_back(e);
    if (rw && wwb != 5'd0) mregs[wwb] = res;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, ".ctl"}, {22'b0, obs_ctl()}, {22'b0, e.ctl});
      if (!e.bubble) begin
        check_eq({e.tag, ".rd1"},  RdData1_EX, e.rd1);
        check_eq({e.tag, ".rd2"},  RdData2_EX, e.rd2);
        check_eq({e.tag, ".simm"}, SignImm_EX, e.simm);
        check_eq({e.tag, ".regs"}, {17'b0, Rs_EX, Rt_EX, Rd_EX}, {17'b0, e.rs, e.rt, e.rd});
      end
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  a, b, c;
    logic [15:0] imm;
    a = 5'($urandom_range(0, 31));
    b = 5'($urandom_range(0, 31));
    c = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 10))
      0: return {6'b000000, a, b, c, 5'b0, 6'b100000};
      1: return {6'b000000, a, b, c, 5'b0, 6'b100010};
      2: return {6'b000000, a, b, c, 5'b0, 6'b100100};
      3: return {6'b000000, a, b, c, 5'b0, 6'b100101};
      4: return {6'b000000, a, b, c, 5'b0, 6'b101010};
      5: return {6'b100011, a, b, imm};
      6: return {6'b101011, a, b, imm};
      7: return {6'b000100, a, b, imm};
      8: return {6'b001000, a, b, imm};
      9: return {6'b000010, a, b, imm};
      default: return {6'b111111, a, b, imm};
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; flush = 1'b0; Instr_ID = 32'h0; MemRead_EX = 1'b0;
    WriteReg_EX = 5'd0; RegWrite_WB = 1'b0; WriteReg_WB = 5'd0; Result_WB = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    #3;
    check_eq("rst.ctl", {22'b0, obs_ctl()}, 32'h0);
    check_eq("rst.rd1", RdData1_EX, 32'h0);
    check_eq("rst.rd2", RdData2_EX, 32'h0);
    check_eq("rst.simm", SignImm_EX, 32'h0);
    check_eq("rst.regs", {17'b0, Rs_EX, Rt_EX, Rd_EX}, 32'h0);
    check_eq("rst.jump", {31'b0, Jump_IDM1}, 32'h0);
    check_eq("rst.stall", {31'b0, LoadStall_ID}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    step("nop0",     32'h00000000, 0, 0, 0, 0, 0, 0);
    step("read_r5",  32'h00A00820, 0, 0, 0, 0, 0, 0);
    step("wb_r8",    32'h00000000, 0, 0, 1, 5'd8, 32'h1234, 0);
    step("add_r8",   32'h01005020, 0, 0, 0, 0, 0, 0);
    step("wb_r0",    32'h00000000, 0, 0, 1, 5'd0, 32'hFFFF, 0);
    step("read_r0",  32'h00000820, 0, 0, 0, 0, 0, 0);
    step("wb_r9",    32'h00000000, 0, 0, 1, 5'd9, 32'h99, 0);
    step("wb_r4",    32'h00000000, 0, 0, 1, 5'd4, 32'h44, 0);
    step("stall_rs", 32'h01241822, 1, 5'd9, 0, 0, 0, 0);
    step("nostall0", 32'h01241822, 1, 5'd0, 0, 0, 0, 0);
    step("stall_rt", 32'h01241822, 1, 5'd4, 0, 0, 0, 0);
    step("noload",   32'h01241822, 0, 5'd9, 0, 0, 0, 0);
    step("addi_rt",  32'h2027FFFF, 1, 5'd7, 0, 0, 0, 0);
    step("jump",     32'h08000100, 0, 0, 0, 0, 0, 0);
    step("j_stall",  32'h09200000, 1, 5'd9, 0, 0, 0, 0);
    step("lw_flush", 32'h8D020004, 0, 0, 0, 0, 0, 1);
    step("lw",       32'h8D020004, 0, 0, 0, 0, 0, 0);
    step("sw",       32'hAD020008, 0, 0, 0, 0, 0, 0);
    step("beq",      32'h11240010, 0, 0, 0, 0, 0, 0);
    step("fl_stall", 32'h01241822, 1, 5'd9, 0, 0, 0, 1);
    step("bad_fn",   32'h01241827, 0, 0, 0, 0, 0, 0);
    step("bad_op",   32'hFC000000, 0, 0, 0, 0, 0, 0);
    step("wb_r6a",   32'h00000000, 0, 0, 1, 5'd6, 32'h1111, 0);
    step("wb_r6_rd", 32'h00C63020, 0, 0, 1, 5'd6, 32'hABCD, 0);
    step("r6_after", 32'h00C00820, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      ins = rnd_instr();
      step("rnd", ins, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? ins[25:21] : 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- ID stage of the 5-stage MIPS pipeline, directly downstream of fetch.
- Consumes the fetched instruction word and decodes it. Resolves jumps back to fetch one stage early.
- Holds the 32x32 register file and detects load-use hazards.
- Drives the ID/EX pipeline register that feeds execute.

Parameters:
- NREG, 32, number of architectural registers (index width 5).
- DW, 32, datapath width.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; next ID/EX contents become a bubble.
- Instr_ID  in  32  instruction word from fetch (FetchData_IF).
- MemRead_EX  in  1  instruction currently in EX is a load.
- WriteReg_EX  in  5  destination register of the EX instruction.
- RegWrite_WB  in  1  writeback enable.
- WriteReg_WB  in  5  writeback register index.
- Result_WB  in  32  writeback data.
- Jump_IDM1  out  1  combinational; Instr_ID is j (opcode 000010).
- JumpTgt_IDM1  out  26  combinational; Instr_ID[25:0].
- LoadStall_ID  out  1  combinational load-use stall request, ORed into AnyStall.
- RdData1_EX, RdData2_EX  out  32 each  registered rs/rt read data.
- SignImm_EX  out  32  registered sign-extended Instr[15:0].
- Rs_EX, Rt_EX, Rd_EX  out  5 each  registered register fields.
- RegWrite_EX, MemToReg_EX, MemWrite_EX, MemReadOut_EX, AluSrc_EX, RegDst_EX, Branch_EX  out  1 each  registered control bits.
- AluCtl_EX  out  3  registered ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.

Behaviour:
- Reset (reset_n=0, asynchronous): every register-file entry = 0 and every ID/EX output = 0, which is a bubble. The combinational outputs follow Instr_ID; fetch resets Instr_ID to 0, so they are 0.

Decode:
- R-type (opcode 000000): RegWrite=1, RegDst=1. Funct maps to AluCtl: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- lw (100011): RegWrite, MemRead, MemToReg, AluSrc; AluCtl=add.
- sw (101011): MemWrite, AluSrc; AluCtl=add.
- beq (000100): Branch; AluCtl=sub.
- addi (001000): RegWrite, AluSrc; AluCtl=add.
- j (000010): Jump_IDM1=1, with no EX side effects (bubble).
- Any other opcode, or an unknown R-type funct: all control bits 0, treated as a NOP.

Register file:
- Write on posedge clk when RegWrite_WB=1 and WriteReg_WB!=0.
- Register 0 always reads 0 and writes to it are ignored.
- Reads are combinational on Instr[25:21] and Instr[20:16].

Load-use hazard:
- LoadStall_ID=1 when all of these hold: MemRead_EX=1, WriteReg_EX!=0, and WriteReg_EX equals rs, or equals rt for R-type, beq or sw.
- Jump_IDM1 is forced to 0 while LoadStall_ID=1, so fetch holds the PC.

ID/EX update:
- Every posedge, with latency 1.
- If flush=1 or LoadStall_ID=1, all control bits load 0 (bubble). Data and index fields may load any value.
- Otherwise the decoded values are loaded.
- flush and stall in the same cycle give a bubble.

Simultaneous WB write and read of the same register: see the optional feature.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined: if RegWrite_WB=1, WriteReg_WB!=0, and WriteReg_WB matches a read index in the same cycle, the read returns Result_WB (write-through).
- When undefined: the read returns the old register value, and the new value is visible from the next cycle. Software or forwarding must cover the hazard.

Test Plan:
- Reset, then Instr_ID=0x00000000: all EX outputs 0, Jump_IDM1=0, LoadStall_ID=0. Reading r5 gives 0.
- WB writes r8=0x1234 on one cycle. Next cycle Instr_ID=add r10,r8,r0 (0x01005020): RdData1_EX=0x1234, RegWrite_EX=1, RegDst_EX=1, AluCtl_EX=010, Rd_EX=10.
- WB write r0=0xFFFF, then read r0: result is 0.
- MemRead_EX=1, WriteReg_EX=9, Instr_ID=sub r3,r9,r4: LoadStall_ID=1 and the next ID/EX is a bubble (all control 0). The same instruction with WriteReg_EX=0 gives no stall.
- Instr_ID=j 0x0000100 (0x08000100): Jump_IDM1=1, JumpTgt_IDM1=0x0000100, next RegWrite_EX=0. flush=1 with lw in ID gives a bubble in EX.
- Same-cycle WB write r6=0xABCD while Instr_ID reads r6. With REGFILE_BYPASS_EN: RdData1_EX=0xABCD. Without it: RdData1_EX equals the prior r6 value.
